// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory,
// and buffers {pc, instr} pairs in a 2-entry FIFO towards decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic [31:0] pc;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        pop;
    logic        push;

    // A redirect masks the head immediately so decode never consumes a stale entry.
    assign out_valid = (count != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && ((count != 2'd2) || pop);

    assign imem_addr = pc;
    assign out_instr = buf_instr[head];
    assign out_pc    = buf_pc[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= 32'd0;
                buf_instr[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                buf_pc[tail]    <= pc;
                buf_instr[tail] <= imem_rdata;
                tail            <= ~tail;
                pc              <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            // A pop always frees room for a push, so occupancy never drops here.
            if (push && !pop) begin
                count <= count + 2'd1;
            end
        end
    end

endmodule
